// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, default starvation limit and source-select encoding for the writeback port arbiter.
package wb_arb_pkg;
    localparam int REG_NUM_W        = 3;
    localparam int DATA_W           = 8;
    localparam int STARVE_LIMIT_DEF = 4;
    typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_AUX, SEL_AUX_FORCED} sel_t;
endpackage

// File: rtl/wb_starve_cnt.sv
// wb_starve_cnt: saturating count of consecutive denied aux-request cycles; at_limit flags a due forced grant.
module wb_starve_cnt
    import wb_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam logic [3:0] LIM = 4'(LIMIT);
    logic [3:0] cnt;
    always_ff @(posedge Clk)
        if (Reset || clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + 4'd1;
    assign at_limit = cnt == LIM;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline writeback and an aux requester.
// WB_STARVE_GUARD_EN enables the starvation guard (forced aux grant plus pipeline stall); otherwise strict pipeline priority.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 EX_WB_RegWrite,
    input  logic [REG_NUM_W-1:0] EX_WB_Write_Reg_Num,
    input  logic [DATA_W-1:0]    EX_WB_ALUResult,
    input  logic                 Aux_Req,
    input  logic [REG_NUM_W-1:0] Aux_Reg_Num,
    input  logic [DATA_W-1:0]    Aux_Data,
    output logic                 Aux_Grant,
    output logic                 Pipe_Stall,
    output logic                 RF_WriteEn,
    output logic [REG_NUM_W-1:0] RF_Write_Reg_Num,
    output logic [DATA_W-1:0]    RF_Write_Data
);
    sel_t sel;
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end
`ifdef WB_STARVE_GUARD_EN
    logic at_limit;
    wb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .inc     (Aux_Req && !Aux_Grant),
        .clr     (!Aux_Req || Aux_Grant),
        .at_limit(at_limit)
    );
    always_comb
        sel = Reset                  ? SEL_NONE :
              (Aux_Req && at_limit)  ? SEL_AUX_FORCED :
              EX_WB_RegWrite         ? SEL_PIPE :
              Aux_Req                ? SEL_AUX : SEL_NONE;
    // The stalled pipeline write is re-presented next cycle and wins because the counter has cleared.
    assign Pipe_Stall = sel == SEL_AUX_FORCED && EX_WB_RegWrite;
`else
    always_comb
        sel = Reset          ? SEL_NONE :
              EX_WB_RegWrite ? SEL_PIPE :
              Aux_Req        ? SEL_AUX : SEL_NONE;
    assign Pipe_Stall = 1'b0;
`endif
    assign Aux_Grant = sel == SEL_AUX || sel == SEL_AUX_FORCED;
    always_ff @(posedge Clk)
        if (Reset) begin
            RF_WriteEn       <= 1'b0;
            RF_Write_Reg_Num <= '0;
            RF_Write_Data    <= '0;
        end else begin
            RF_WriteEn <= sel != SEL_NONE;
            if (sel == SEL_PIPE) begin
                RF_Write_Reg_Num <= EX_WB_Write_Reg_Num;
                RF_Write_Data    <= EX_WB_ALUResult;
            end else if (Aux_Grant) begin
                RF_Write_Reg_Num <= Aux_Reg_Num;
                RF_Write_Data    <= Aux_Data;
            end
        end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of the writeback port arbiter with STARVE_LIMIT=4.
module tb_wb_port_arbiter;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic       Clk, Reset;
    logic       ex_we, aux_req;
    logic [2:0] ex_num, aux_num;
    logic [7:0] ex_data, aux_data;
    logic       Aux_Grant, Pipe_Stall, RF_WriteEn;
    logic [2:0] RF_Write_Reg_Num;
    logic [7:0] RF_Write_Data;
    int total = 0;
    int bad = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .EX_WB_RegWrite     (ex_we),
        .EX_WB_Write_Reg_Num(ex_num),
        .EX_WB_ALUResult    (ex_data),
        .Aux_Req            (aux_req),
        .Aux_Reg_Num        (aux_num),
        .Aux_Data           (aux_data),
        .Aux_Grant          (Aux_Grant),
        .Pipe_Stall         (Pipe_Stall),
        .RF_WriteEn         (RF_WriteEn),
        .RF_Write_Reg_Num   (RF_Write_Reg_Num),
        .RF_Write_Data      (RF_Write_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] n, input logic [7:0] d,
                         input logic ar, input logic [2:0] an, input logic [7:0] ad);
        ex_we = we; ex_num = n; ex_data = d;
        aux_req = ar; aux_num = an; aux_data = ad;
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        drive(1'b1, 3'd3, 8'hFF, 1'b1, 3'd4, 8'hEE);
        total++; if (Aux_Grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0", Aux_Grant); end
        total++; if (Pipe_Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Pipe_Stall); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== 12'h000)
            begin bad++; $display("FAIL reset_port got=%b/%0d/%h exp=0/0/00", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
        Reset = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
    endtask

    task automatic test_pipe;
        drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        total++; if (Aux_Grant !== 1'b0 || Pipe_Stall !== 1'b0)
            begin bad++; $display("FAIL pipe_comb got=%b%b exp=00", Aux_Grant, Pipe_Stall); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd3, 8'h5A})
            begin bad++; $display("FAIL pipe_port got=%b/%0d/%h exp=1/3/5a", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
    endtask

    task automatic test_aux;
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hC3);
        total++; if (Aux_Grant !== 1'b1 || Pipe_Stall !== 1'b0)
            begin bad++; $display("FAIL aux_comb got=%b%b exp=10", Aux_Grant, Pipe_Stall); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd5, 8'hC3})
            begin bad++; $display("FAIL aux_port got=%b/%0d/%h exp=1/5/c3", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
    endtask

    task automatic test_idle;
        drive(1'b0, 3'd1, 8'h99, 1'b0, 3'd2, 8'h88);
        total++; if (Aux_Grant !== 1'b0) begin bad++; $display("FAIL idle_grant got=%b exp=0", Aux_Grant); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b0, 3'd5, 8'hC3})
            begin bad++; $display("FAIL idle_port got=%b/%0d/%h exp=0/5/c3", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
    endtask

    task automatic test_reg0;
        drive(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 8'h00);
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd0, 8'h77})
            begin bad++; $display("FAIL reg0_port got=%b/%0d/%h exp=1/0/77", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
    endtask

    task automatic test_priority;
        drive(1'b1, 3'd6, 8'h12, 1'b1, 3'd4, 8'h34);
        total++; if (Aux_Grant !== 1'b0) begin bad++; $display("FAIL prio_grant got=%b exp=0", Aux_Grant); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd6, 8'h12})
            begin bad++; $display("FAIL prio_pipe got=%b/%0d/%h exp=1/6/12", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h34);
        total++; if (Aux_Grant !== 1'b1) begin bad++; $display("FAIL prio_aux_grant got=%b exp=1", Aux_Grant); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd4, 8'h34})
            begin bad++; $display("FAIL prio_aux got=%b/%0d/%h exp=1/4/34", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
    endtask

    // Pipe writes every cycle while aux R1=0x11 waits; guarded build forces it on the fifth cycle.
    task automatic test_starve;
        logic [7:0] pd = 8'h20;
        logic       pend = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic       fg = GUARD && i == 4;
            logic [2:0] en;
            logic [7:0] ed;
            drive(1'b1, 3'd7, pd, pend, 3'd1, 8'h11);
            total++; if (Aux_Grant !== fg || Pipe_Stall !== fg)
                begin bad++; $display("FAIL starve_comb[%0d] got=%b%b exp=%b%b", i, Aux_Grant, Pipe_Stall, fg, fg); end
            en = fg ? 3'd1 : 3'd7;
            ed = fg ? 8'h11 : pd;
            tick();
            total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, en, ed})
                begin bad++; $display("FAIL starve_port[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data, en, ed); end
            if (fg) pend = 1'b0;
            else pd = pd + 8'd1;
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
    endtask

    task automatic test_collision;
        for (int i = 0; i < 6; i++) begin
            logic       fg = GUARD && i == 4;
            logic [7:0] ed = fg ? 8'h55 : 8'hAA;
            drive(1'b1, 3'd2, 8'hAA, !(GUARD && i == 5), 3'd2, 8'h55);
            total++; if (Aux_Grant !== fg)
                begin bad++; $display("FAIL coll_grant[%0d] got=%b exp=%b", i, Aux_Grant, fg); end
            tick();
            total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, 3'd2, ed})
                begin bad++; $display("FAIL coll_port[%0d] got=%b/%0d/%h exp=1/2/%h", i, RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data, ed); end
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
    endtask

    task automatic test_reset_mid_wait;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd3, 8'h33);
            total++; if (Aux_Grant !== 1'b0)
                begin bad++; $display("FAIL rmw_pre_grant[%0d] got=%b exp=0", i, Aux_Grant); end
            tick();
        end
        Reset = 1'b1;
        #1;
        total++; if (Aux_Grant !== 1'b0 || Pipe_Stall !== 1'b0)
            begin bad++; $display("FAIL rmw_reset_comb got=%b%b exp=00", Aux_Grant, Pipe_Stall); end
        tick();
        total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== 12'h000)
            begin bad++; $display("FAIL rmw_reset_port got=%b/%0d/%h exp=0/0/00", RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data); end
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic       fg = GUARD && i == 4;
            logic [2:0] en = fg ? 3'd3 : 3'd6;
            logic [7:0] ed = fg ? 8'h33 : 8'h66;
            drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd3, 8'h33);
            total++; if (Aux_Grant !== fg || Pipe_Stall !== fg)
                begin bad++; $display("FAIL rmw_comb[%0d] got=%b%b exp=%b%b", i, Aux_Grant, Pipe_Stall, fg, fg); end
            tick();
            total++; if ({RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data} !== {1'b1, en, ed})
                begin bad++; $display("FAIL rmw_port[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, RF_WriteEn, RF_Write_Reg_Num, RF_Write_Data, en, ed); end
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        total++; if (RF_WriteEn !== 1'b0)
            begin bad++; $display("FAIL rmw_idle_en got=%b exp=0", RF_WriteEn); end
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        test_reset();
        test_pipe();
        test_aux();
        test_idle();
        test_reg0();
        test_priority();
        test_starve();
        test_collision();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
